// File: rtl/mio_bus_responder.sv
// ---------------------------------------------------------------------------
// mio_bus_responder
//   Far-end responder for the CPU memory/IO (MIO) bus. A request is latched
//   in IDLE and decoded to the external data RAM or to one of the on-board
//   peripheral registers (7-segment, LED/switch IO, free-running cycle
//   counter). RAM accesses spend RAM_WAIT cycles in WAIT before the single
//   MIO_ready acknowledge; peripheral and unmapped accesses acknowledge on
//   the very next cycle.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   CPU_MIO       : request strobe, held by the CPU until MIO_ready
//   mem_w         : 1 = write, 0 = read
//   addr_bus      : byte address (bits [1:0] ignored)
//   Cpu_data2bus  : write data from the CPU
//   Cpu_data4bus  : read data back to the CPU, valid while MIO_ready=1
//   MIO_ready     : one-cycle acknowledge
//   bus_err       : sticky flag, set by any access to an unmapped address
//   ram_addr/ram_din/ram_we/ram_dout : synchronous RAM port
//   SW            : board switches, readable through the IO address
//   led_out       : LED register (IO write, low byte)
//   seg_out       : 7-segment display register
// ---------------------------------------------------------------------------
module mio_bus_responder #(
  parameter int RAM_WAIT   = 2,
  parameter int RAM_AWIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CPU_MIO,
  input  logic                  mem_w,
  input  logic [31:0]           addr_bus,
  input  logic [31:0]           Cpu_data2bus,
  output logic [31:0]           Cpu_data4bus,
  output logic                  MIO_ready,
  output logic                  bus_err,
  output logic [RAM_AWIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_we,
  input  logic [31:0]           ram_dout,
  input  logic [15:0]           SW,
  output logic [7:0]            led_out,
  output logic [31:0]           seg_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_waitCnt;
  logic                  r_write;
  logic [RAM_AWIDTH-1:0] r_ramAddr;
  logic [31:0]           r_ramDin;
  logic [31:0]           r_rdata;
  logic                  r_busErr;
  logic [7:0]            r_led;
  logic [31:0]           r_seg;
  logic [31:0]           r_cycleCnt;

  logic                  w_accept;
  logic                  w_ramDone;
  logic                  w_hitRam;
  logic                  w_hitSeg;
  logic                  w_hitIo;
  logic                  w_hitCnt;
  logic                  w_hitNone;
  logic [31:0]           w_periphRead;
  logic                  w_unused;

  // Byte-lane bits are meaningless on this word-only bus.
  assign w_unused = ^addr_bus[1:0];

  // Address decode on the word address; RAM occupies the bottom 4 KiB.
  assign w_hitRam  = (addr_bus[31:12] == 20'h0_0000);
  assign w_hitSeg  = (addr_bus[31:2] == 30'h3800_0000);
  assign w_hitIo   = (addr_bus[31:2] == 30'h3C00_0000);
  assign w_hitCnt  = (addr_bus[31:2] == 30'h3C00_0001);
  assign w_hitNone = !(w_hitRam || w_hitSeg || w_hitIo || w_hitCnt);

  // Read data for the non-RAM targets; unmapped reads return zero.
  always_comb begin
    w_periphRead = 32'h0;
    if (w_hitSeg)      w_periphRead = r_seg;
    else if (w_hitIo)  w_periphRead = {16'h0, SW};
    else if (w_hitCnt) w_periphRead = r_cycleCnt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic. A request is only accepted from IDLE, so a strobe
  // still held high during ACK cannot start a second transaction.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_ramDone   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CPU_MIO) begin
          w_accept    = 1'b1;
          w_nextState = w_hitRam ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_ramDone   = 1'b1;
          w_nextState = S_ACK;
        end
      end
      S_ACK:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Transaction datapath: latches the request on acceptance, performs the
  // peripheral side effects on that same edge, and captures RAM read data
  // on the last wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waitCnt <= 4'd0;
      r_write   <= 1'b0;
      r_ramAddr <= '0;
      r_ramDin  <= 32'h0;
      r_rdata   <= 32'h0;
      r_busErr  <= 1'b0;
      r_led     <= 8'h0;
      r_seg     <= 32'h0;
    end else begin
      if (w_accept) begin
        r_write <= mem_w;
        if (w_hitRam) begin
          r_ramAddr <= addr_bus[RAM_AWIDTH+1:2];
          r_ramDin  <= Cpu_data2bus;
          r_waitCnt <= 4'(RAM_WAIT - 1);
        end
        if (w_hitNone) r_busErr <= 1'b1;
        if (mem_w) begin
          if (w_hitSeg) r_seg <= Cpu_data2bus;
          if (w_hitIo)  r_led <= Cpu_data2bus[7:0];
        end else if (!w_hitRam) begin
          r_rdata <= w_periphRead;
        end
      end
      if (r_state == S_WAIT && r_waitCnt != 4'd0) r_waitCnt <= r_waitCnt - 4'd1;
      if (w_ramDone && !r_write) r_rdata <= ram_dout;
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) r_cycleCnt <= 32'h0;
    else     r_cycleCnt <= r_cycleCnt + 32'd1;
  end

  // The write strobe is gated by rst so an aborted write never lands.
  assign ram_we       = w_ramDone && r_write && !rst;
  assign MIO_ready    = (r_state == S_ACK);
  assign ram_addr     = r_ramAddr;
  assign ram_din      = r_ramDin;
  assign Cpu_data4bus = r_rdata;
  assign bus_err      = r_busErr;
  assign led_out      = r_led;
  assign seg_out      = r_seg;

endmodule

// File: tb/tb_mio_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_responder
//   Drives CPU-side MIO transactions, emulates the synchronous RAM, and
//   compares every cycle against a transaction-level reference model that
//   derives latency and data from the address map.
// ---------------------------------------------------------------------------
module tb_mio_bus_responder;

  localparam int RAM_WAIT   = 2;
  localparam int RAM_AWIDTH = 10;
  localparam int RAM_WORDS  = 1 << RAM_AWIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  CPU_MIO;
  logic                  mem_w;
  logic [31:0]           addr_bus;
  logic [31:0]           Cpu_data2bus;
  logic [31:0]           Cpu_data4bus;
  logic                  MIO_ready;
  logic                  bus_err;
  logic [RAM_AWIDTH-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic                  ram_we;
  logic [31:0]           ram_dout;
  logic [15:0]           SW;
  logic [7:0]            led_out;
  logic [31:0]           seg_out;

  mio_bus_responder #(.RAM_WAIT(RAM_WAIT), .RAM_AWIDTH(RAM_AWIDTH)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .addr_bus(addr_bus), .Cpu_data2bus(Cpu_data2bus),
    .Cpu_data4bus(Cpu_data4bus), .MIO_ready(MIO_ready), .bus_err(bus_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .SW(SW), .led_out(led_out), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle c is the interval following the c-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM emulation: registered read, write on the edge.
  logic [31:0] ramDev [RAM_WORDS];
  initial for (int i = 0; i < RAM_WORDS; i++) ramDev[i] <= 32'hA000_0000 + 32'(i);
  always @(posedge clk) begin
    if (ram_we === 1'b1) ramDev[ram_addr] <= ram_din;
    ram_dout <= ramDev[ram_addr];
  end

  // Independent record of every RAM write strobe.
  int                    weCount = 0;
  logic [RAM_AWIDTH-1:0] lastWeAddr;
  logic [31:0]           lastWeDin;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      weCount    <= weCount + 1;
      lastWeAddr <= ram_addr;
      lastWeDin  <= ram_din;
    end
  end

  // Reference model state.
  typedef enum int {R_RAM, R_SEG, R_IO, R_CNT, R_NONE} region_t;
  logic [31:0]           refMem [RAM_WORDS];
  logic [7:0]            expLed;
  logic [31:0]           expSeg;
  logic                  expBusErr;
  logic [31:0]           expData;
  logic                  expRead;
  logic [RAM_AWIDTH-1:0] expRamAddr;
  logic [31:0]           expRamDin;
  int                    readyCycle = -1;
  int                    weCycle    = -1;
  int                    relCyc     = 0;
  bit                    checking   = 1'b0;

  int checks = 0;
  int errors = 0;

  // Address map as a plain range lookup.
  function automatic region_t regionOf(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (a < 32'h0000_1000)  return R_RAM;
    if (w == 32'hE000_0000) return R_SEG;
    if (w == 32'hF000_0000) return R_IO;
    if (w == 32'hF000_0004) return R_CNT;
    return R_NONE;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      check1("MIO_ready", MIO_ready, cyc == readyCycle);
      if (cyc == readyCycle && expRead) check32("Cpu_data4bus", Cpu_data4bus, expData);
      check1("ram_we", ram_we, cyc == weCycle);
      if (cyc == weCycle) begin
        check32("ram_addr", 32'(ram_addr), 32'(expRamAddr));
        check32("ram_din", ram_din, expRamDin);
      end
      check32("led_out", {24'h0, led_out}, {24'h0, expLed});
      check32("seg_out", seg_out, expSeg);
      check1("bus_err", bus_err, expBusErr);
    end
  end

  // Holds rst for n cycles; a pending acknowledge or write is cancelled.
  task automatic applyReset(input int n);
    rst     = 1'b1;
    CPU_MIO = 1'b0;
    if (weCycle >= cyc)   weCycle    = -1;
    if (readyCycle > cyc) readyCycle = -1;
    repeat (n) begin
      @(posedge clk); #1;
      expLed    = 8'h0;
      expSeg    = 32'h0;
      expBusErr = 1'b0;
    end
    rst    = 1'b0;
    relCyc = cyc;
  endtask

  // One complete CPU transaction; called in an IDLE cycle, returns in the
  // cycle after the acknowledge with the observed latency and read data.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rdata, output int lat);
    int                    k;
    region_t               rg;
    logic [RAM_AWIDTH-1:0] word;
    k    = cyc;
    rg   = regionOf(a);
    word = a[RAM_AWIDTH+1:2];
    CPU_MIO      = 1'b1;
    mem_w        = wr;
    addr_bus     = a;
    Cpu_data2bus = d;
    expRead      = !wr;
    readyCycle   = k + 1;
    case (rg)
      R_RAM: begin
        readyCycle = k + 1 + RAM_WAIT;
        if (wr) begin
          weCycle    = k + RAM_WAIT;
          expRamAddr = word;
          expRamDin  = d;
        end else begin
          expData = refMem[word];
        end
      end
      R_SEG:   expData = expSeg;
      R_IO:    expData = {16'h0, SW};
      R_CNT:   expData = 32'(k - relCyc);
      default: expData = 32'h0;
    endcase
    @(posedge clk); #1;
    if (wr) begin
      case (rg)
        R_RAM:   refMem[word] = d;
        R_SEG:   expSeg = d;
        R_IO:    expLed = d[7:0];
        default: ;
      endcase
    end
    if (rg == R_NONE) expBusErr = 1'b1;
    mem_w        = 1'($urandom);
    addr_bus     = $urandom;
    Cpu_data2bus = $urandom;
    lat   = -1;
    rdata = 32'h0;
    while (cyc <= readyCycle) begin
      if (MIO_ready === 1'b1 && lat < 0) begin
        lat   = cyc - k;
        rdata = Cpu_data4bus;
      end
      @(posedge clk); #1;
    end
    CPU_MIO = 1'b0;
  endtask

  // Outputs expected straight after any reset.
  task automatic checkOutput(input string tag);
    check32({tag, " Cpu_data4bus"}, Cpu_data4bus, 32'h0);
    check1({tag, " MIO_ready"}, MIO_ready, 1'b0);
    check1({tag, " ram_we"}, ram_we, 1'b0);
    check1({tag, " bus_err"}, bus_err, 1'b0);
    check32({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
    check32({tag, " ram_din"}, ram_din, 32'h0);
    check32({tag, " led_out"}, {24'h0, led_out}, 32'h0);
    check32({tag, " seg_out"}, seg_out, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] a;
    int          lat;
    int          weBase;
    int          pick;

    rst = 1'b1; CPU_MIO = 1'b0; mem_w = 1'b0;
    addr_bus = 32'h0; Cpu_data2bus = 32'h0; SW = 16'h0;
    for (int i = 0; i < RAM_WORDS; i++) refMem[i] = 32'hA000_0000 + 32'(i);

    @(posedge clk); #1;
    applyReset(3);
    checking = 1'b1;
    checkOutput("reset");

    // RAM write then read back.
    weBase = weCount;
    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat);
    check32("ram wr latency", 32'(lat), 32'd3);
    check32("ram wr strobes", 32'(weCount - weBase), 32'd1);
    check32("ram wr addr", 32'(lastWeAddr), 32'd4);
    check32("ram wr data", lastWeDin, 32'hDEAD_BEEF);
    weBase = weCount;
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    check32("ram rd latency", 32'(lat), 32'd3);
    check32("ram rd data", rd, 32'hDEAD_BEEF);
    check32("ram rd strobes", 32'(weCount - weBase), 32'd0);

    // LED / switch IO.
    applyStimulus(1'b1, 32'hF000_0000, 32'h0000_01A5, rd, lat);
    check32("io wr latency", 32'(lat), 32'd1);
    check32("led value", {24'h0, led_out}, 32'h0000_00A5);
    SW = 16'h8001;
    applyStimulus(1'b0, 32'hF000_0000, 32'h0, rd, lat);
    check32("sw read", rd, 32'h0000_8001);

    // Seven-segment register.
    applyStimulus(1'b1, 32'hE000_0000, 32'h1234_5678, rd, lat);
    applyStimulus(1'b0, 32'hE000_0000, 32'h0, rd, lat);
    check32("seg read", rd, 32'h1234_5678);
    check32("seg value", seg_out, 32'h1234_5678);

    // Two counter reads 5 idle cycles apart.
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, c1, lat);
    repeat (5) begin @(posedge clk); #1; end
    applyStimulus(1'b0, 32'hF000_0004, 32'h0, c2, lat);
    check32("cnt delta", c2 - c1, 32'd7);

    // Unmapped access and stickiness of bus_err.
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, rd, lat);
    check32("unmapped latency", 32'(lat), 32'd1);
    check32("unmapped data", rd, 32'h0);
    check1("bus_err set", bus_err, 1'b1);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    applyStimulus(1'b1, 32'hF000_0000, 32'h0000_0033, rd, lat);
    applyStimulus(1'b0, 32'hE000_0000, 32'h0, rd, lat);
    check1("bus_err sticky", bus_err, 1'b1);

    // Reset during the final wait cycle of a RAM write.
    weBase = weCount;
    CPU_MIO = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0040; Cpu_data2bus = 32'hCAFE_F00D;
    repeat (RAM_WAIT) begin @(posedge clk); #1; end
    applyReset(2);
    checkOutput("abort");
    check32("abort strobes", 32'(weCount - weBase), 32'd0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, rd, lat);
    check32("post-abort latency", 32'(lat), 32'd3);
    check32("post-abort data", rd, 32'hA000_0010);

    // Randomised traffic across the whole map.
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      SW   = 16'($urandom);
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2: a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
        3:       a = 32'h0000_0FFC + 32'($urandom_range(0, 3));
        4, 5:    a = 32'hE000_0000 + 32'($urandom_range(0, 3));
        6:       a = 32'hF000_0000 + 32'($urandom_range(0, 3));
        7:       a = 32'hF000_0004 + 32'($urandom_range(0, 3));
        8:       a = 32'h0000_1000 + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      applyStimulus(1'($urandom), a, $urandom, rd, lat);
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
